// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl: game-state controller for the 4x4 card-matching game (cursor, flips, pairs, attempts).
// Latency: every effect is registered and appears on the clock edge after the triggering pulse.
// Backpressure: none; inputs are one-cycle pulses, one button action per cycle (sel>up>down>left>right).
// Optional feature: define ATTEMPT_LIMIT_EN to add the S_LOST state after MAX_ATTEMPTS attempts.
module memory_game_ctrl #(
  parameter logic [63:0] LAYOUT        = 64'h0123456776543210,
  parameter int unsigned REVEAL_FRAMES = 60,
  parameter int unsigned MAX_ATTEMPTS  = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  output logic [3:0]  cursor,
  output logic [15:0] face_up,
  output logic [15:0] matched,
  output logic [7:0]  attempts,
  output logic [3:0]  pairs,
  output logic        game_done,
  output logic        game_lost
);

`ifdef ATTEMPT_LIMIT_EN
  typedef enum logic [2:0] {
    S_PICK1 = 3'd0,
    S_PICK2 = 3'd1,
    S_SHOW  = 3'd2,
    S_DONE  = 3'd3,
    S_LOST  = 3'd4
  } state_t;
  localparam logic [7:0] ATT_MAX = 8'(MAX_ATTEMPTS);
`else
  typedef enum logic [2:0] {
    S_PICK1 = 3'd0,
    S_PICK2 = 3'd1,
    S_SHOW  = 3'd2,
    S_DONE  = 3'd3
  } state_t;
`endif

  localparam logic [7:0] REVEAL_LAST = 8'(REVEAL_FRAMES);

  state_t      state, nxt_state;
  logic [15:0] flipped, nxt_flipped;
  logic [15:0] nxt_matched;
  logic [15:0] nxt_face_up;
  logic [3:0]  first, nxt_first;
  logic [3:0]  nxt_cursor;
  logic [3:0]  nxt_pairs;
  logic [7:0]  nxt_attempts;
  logic [7:0]  reveal_cnt, nxt_reveal;

  // Card type lookup; only the low three bits of each layout nibble identify a pair.
  function automatic logic [2:0] card_type(input logic [3:0] p);
    card_type = LAYOUT[{p, 2'b00} +: 3];
  endfunction

  // Next-state and next-output computation for the whole game.
  always_comb begin
    nxt_state    = state;
    nxt_flipped  = flipped;
    nxt_matched  = matched;
    nxt_first    = first;
    nxt_cursor   = cursor;
    nxt_pairs    = pairs;
    nxt_attempts = attempts;
    nxt_reveal   = reveal_cnt;

    case (state)
      S_PICK1, S_PICK2: begin
        if (btn_sel) begin
          // A card already showing (flipped or matched) cannot be picked.
          if (!face_up[cursor]) begin
            if (state == S_PICK1) begin
              nxt_first           = cursor;
              nxt_flipped[cursor] = 1'b1;
              nxt_state           = S_PICK2;
            end else begin
              nxt_attempts = (attempts == 8'hFF) ? attempts : attempts + 8'd1;
              if (card_type(first) == card_type(cursor)) begin
                nxt_matched = matched | (16'd1 << first) | (16'd1 << cursor);
                nxt_flipped = 16'd0;
                nxt_pairs   = pairs + 4'd1;
                // Completing the last pair wins even on the final allowed attempt.
                if (pairs == 4'd7) begin
                  nxt_state = S_DONE;
                end
`ifdef ATTEMPT_LIMIT_EN
                else if (nxt_attempts == ATT_MAX) begin
                  nxt_state = S_LOST;
                end
`endif
                else begin
                  nxt_state = S_PICK1;
                end
              end else begin
                nxt_flipped[cursor] = 1'b1;
                nxt_reveal          = 8'd0;
                nxt_state           = S_SHOW;
              end
            end
          end
        end else if (btn_up) begin
          nxt_cursor = {cursor[3:2] - 2'd1, cursor[1:0]};
        end else if (btn_down) begin
          nxt_cursor = {cursor[3:2] + 2'd1, cursor[1:0]};
        end else if (btn_left) begin
          nxt_cursor = {cursor[3:2], cursor[1:0] - 2'd1};
        end else if (btn_right) begin
          nxt_cursor = {cursor[3:2], cursor[1:0] + 2'd1};
        end
      end

      S_SHOW: begin
        // Buttons are ignored here; only frame ticks advance the reveal.
        if (frame_tick) begin
          nxt_reveal = reveal_cnt + 8'd1;
          if (nxt_reveal == REVEAL_LAST) begin
            nxt_flipped = 16'd0;
`ifdef ATTEMPT_LIMIT_EN
            nxt_state   = (attempts == ATT_MAX) ? S_LOST : S_PICK1;
`else
            nxt_state   = S_PICK1;
`endif
          end
        end
      end

`ifdef ATTEMPT_LIMIT_EN
      S_DONE, S_LOST: begin
`else
      S_DONE: begin
`endif
        // Select restarts the game; everything else is ignored.
        if (btn_sel) begin
          nxt_matched  = 16'd0;
          nxt_flipped  = 16'd0;
          nxt_attempts = 8'd0;
          nxt_pairs    = 4'd0;
          nxt_cursor   = 4'd0;
          nxt_state    = S_PICK1;
        end
      end

      default: begin
        nxt_state = S_PICK1;
      end
    endcase

`ifdef ATTEMPT_LIMIT_EN
    nxt_face_up = (nxt_state == S_LOST) ? 16'hFFFF : (nxt_matched | nxt_flipped);
`else
    nxt_face_up = nxt_matched | nxt_flipped;
`endif
  end

  // Game state register; all outputs are registered copies of the next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_PICK1;
      cursor     <= 4'd0;
      flipped    <= 16'd0;
      matched    <= 16'd0;
      face_up    <= 16'd0;
      attempts   <= 8'd0;
      pairs      <= 4'd0;
      reveal_cnt <= 8'd0;
      first      <= 4'd0;
      game_done  <= 1'b0;
    end else begin
      state      <= nxt_state;
      cursor     <= nxt_cursor;
      flipped    <= nxt_flipped;
      matched    <= nxt_matched;
      face_up    <= nxt_face_up;
      attempts   <= nxt_attempts;
      pairs      <= nxt_pairs;
      reveal_cnt <= nxt_reveal;
      first      <= nxt_first;
      game_done  <= (nxt_state == S_DONE);
    end
  end

`ifdef ATTEMPT_LIMIT_EN
  // Loss flag, registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      game_lost <= 1'b0;
    end else begin
      game_lost <= (nxt_state == S_LOST);
    end
  end
`else
  logic unused_max_attempts;
  assign unused_max_attempts = (MAX_ATTEMPTS == 0);
  assign game_lost = 1'b0;
`endif

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Self-checking bench for memory_game_ctrl: scoreboard of expected output snapshots, one task per scenario.
module tb_memory_game_ctrl;

`ifdef ATTEMPT_LIMIT_EN
  localparam int MAXA = 2;
`else
  localparam int MAXA = 20;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_tick = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
  logic [3:0]  cursor;
  logic [15:0] face_up;
  logic [15:0] matched;
  logic [7:0]  attempts;
  logic [3:0]  pairs;
  logic        game_done;
  logic        game_lost;

  memory_game_ctrl #(
    .LAYOUT(64'h0123456776543210),
    .REVEAL_FRAMES(60),
    .MAX_ATTEMPTS(MAXA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel), .cursor(cursor), .face_up(face_up), .matched(matched),
    .attempts(attempts), .pairs(pairs), .game_done(game_done), .game_lost(game_lost)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  cursor;
    logic [15:0] face_up;
    logic [15:0] matched;
    logic [7:0]  attempts;
    logic [3:0]  pairs;
    logic        done;
    logic        lost;
  } obs_t;

  // Button encoding {tick, sel, up, down, left, right}
  localparam logic [5:0] B_NONE  = 6'b000000;
  localparam logic [5:0] B_RIGHT = 6'b000001;
  localparam logic [5:0] B_LEFT  = 6'b000010;
  localparam logic [5:0] B_DOWN  = 6'b000100;
  localparam logic [5:0] B_UP    = 6'b001000;
  localparam logic [5:0] B_SEL   = 6'b010000;
  localparam logic [5:0] B_TICK  = 6'b100000;

  obs_t       sb[$];
  logic [5:0] stim_q[$];
  obs_t       exp_s, got, e;
  logic [5:0] b;
  int         checks = 0;
  int         errors = 0;

  function automatic obs_t snap();
    return {cursor, face_up, matched, attempts, pairs, game_done, game_lost};
  endfunction

  // Queue one stimulus cycle together with the snapshot expected after it.
  task automatic add(input logic [5:0] bt);
    stim_q.push_back(bt);
    sb.push_back(exp_s);
  endtask

  task automatic step(input logic [5:0] bt);
    {frame_tick, btn_sel, btn_up, btn_down, btn_left, btn_right} = bt;
    @(posedge clk);
    #1;
    {frame_tick, btn_sel, btn_up, btn_down, btn_left, btn_right} = B_NONE;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_s = '0;
  endtask

  // Expected-cursor walk: right until the column matches, then down until the row matches.
  task automatic move_to(input logic [3:0] t);
    while (exp_s.cursor[1:0] != t[1:0]) begin
      exp_s.cursor = {exp_s.cursor[3:2], exp_s.cursor[1:0] + 2'd1};
      add(B_RIGHT);
    end
    while (exp_s.cursor[3:2] != t[3:2]) begin
      exp_s.cursor = {exp_s.cursor[3:2] + 2'd1, exp_s.cursor[1:0]};
      add(B_DOWN);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    exp_s = '0;
    sb.push_back(exp_s);
    #1;
    got = snap();
    e = sb.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL reset_async got %h expected %h", got, e); end
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(exp_s);
    got = snap();
    e = sb.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL reset_held got %h expected %h", got, e); end
    rst_n = 1'b1;
  endtask

  task automatic test_cursor();
    int n = 0;
    reset_dut();
    exp_s.cursor = 4'd1;  add(B_RIGHT);
    exp_s.cursor = 4'd2;  add(B_RIGHT);
    exp_s.cursor = 4'd3;  add(B_RIGHT);
    exp_s.cursor = 4'd0;  add(B_RIGHT);
    exp_s.cursor = 4'd1;  add(B_RIGHT);
    exp_s.cursor = 4'd13; add(B_UP);
    exp_s.cursor = 4'd1;  add(B_DOWN);
    exp_s.cursor = 4'd0;  add(B_LEFT);
    exp_s.cursor = 4'd3;  add(B_LEFT);
    exp_s.cursor = 4'd15; add(B_UP | B_LEFT);
    exp_s.cursor = 4'd3;  add(B_DOWN | B_LEFT | B_RIGHT);
    exp_s.cursor = 4'd0;  add(B_RIGHT | B_TICK);
    while (stim_q.size() > 0) begin
      b = stim_q.pop_front();
      step(b);
      got = snap();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("FAIL cursor[%0d] got %h expected %h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_match();
    int n = 0;
    reset_dut();
    exp_s.face_up = 16'h0001; add(B_SEL | B_RIGHT);
    exp_s.cursor = 4'd12;     add(B_UP);
    exp_s.cursor = 4'd15;     add(B_LEFT);
    exp_s.matched = 16'h8001; exp_s.face_up = 16'h8001; exp_s.pairs = 4'd1; exp_s.attempts = 8'd1;
    add(B_SEL);
    exp_s.cursor = 4'd12;     add(B_RIGHT);
    exp_s.face_up = 16'h9001; add(B_SEL);
    while (stim_q.size() > 0) begin
      b = stim_q.pop_front();
      step(b);
      got = snap();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("FAIL match[%0d] got %h expected %h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_mismatch();
    int n = 0;
    reset_dut();
    exp_s.face_up = 16'h0001; add(B_SEL);
    exp_s.cursor = 4'd1;      add(B_RIGHT);
    exp_s.face_up = 16'h0003; exp_s.attempts = 8'd1; add(B_SEL);
    for (int i = 1; i <= 59; i++) begin
      add(B_TICK | ((i == 30) ? B_SEL : (i == 31) ? B_RIGHT : (i == 32) ? B_UP : B_NONE));
    end
    exp_s.face_up = 16'h0000; add(B_TICK);
    exp_s.face_up = 16'h0002; add(B_SEL);
    while (stim_q.size() > 0) begin
      b = stim_q.pop_front();
      step(b);
      got = snap();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("FAIL mismatch[%0d] got %h expected %h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_ignore();
    int n = 0;
    reset_dut();
    exp_s.face_up = 16'h0001; add(B_SEL);
    exp_s.cursor = 4'd12; add(B_UP);
    exp_s.cursor = 4'd15; add(B_LEFT);
    exp_s.matched = 16'h8001; exp_s.face_up = 16'h8001; exp_s.pairs = 4'd1; exp_s.attempts = 8'd1;
    add(B_SEL);
    exp_s.cursor = 4'd12; add(B_RIGHT);
    exp_s.cursor = 4'd0;  add(B_DOWN);
    add(B_SEL);
    exp_s.cursor = 4'd1;  add(B_RIGHT);
    exp_s.face_up = 16'h8003; add(B_SEL);
    add(B_SEL);
    exp_s.cursor = 4'd0;  add(B_LEFT);
    add(B_SEL);
    exp_s.cursor = 4'd12; add(B_UP);
    exp_s.cursor = 4'd13; add(B_RIGHT);
    exp_s.cursor = 4'd14; add(B_RIGHT);
    exp_s.matched = 16'hC003; exp_s.face_up = 16'hC003; exp_s.pairs = 4'd2; exp_s.attempts = 8'd2;
    add(B_SEL);
    while (stim_q.size() > 0) begin
      b = stim_q.pop_front();
      step(b);
      got = snap();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("FAIL ignore[%0d] got %h expected %h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_full_game();
    int n = 0;
    logic [3:0] q;
    reset_dut();
    for (int p = 0; p < 8; p++) begin
      move_to(4'(p));
      exp_s.face_up = exp_s.face_up | (16'd1 << p);
      add(B_SEL);
      q = 4'(15 - p);
      move_to(q);
      exp_s.matched = exp_s.matched | (16'd1 << p) | (16'd1 << q);
      exp_s.face_up = exp_s.matched;
      exp_s.pairs = exp_s.pairs + 4'd1;
      exp_s.attempts = exp_s.attempts + 8'd1;
      exp_s.done = (p == 7);
      add(B_SEL);
    end
    add(B_RIGHT);
    add(B_UP | B_TICK);
    exp_s = '0; add(B_SEL);
    exp_s.face_up = 16'h0001; add(B_SEL);
    while (stim_q.size() > 0) begin
      b = stim_q.pop_front();
      step(b);
      got = snap();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("FAIL full_game[%0d] got %h expected %h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_lost();
    int n = 0;
    reset_dut();
    exp_s.face_up = 16'h0001; add(B_SEL);
    exp_s.cursor = 4'd1; add(B_RIGHT);
    exp_s.face_up = 16'h0003; exp_s.attempts = 8'd1; add(B_SEL);
    for (int i = 1; i <= 59; i++) add(B_TICK);
    exp_s.face_up = 16'h0000; add(B_TICK);
    exp_s.face_up = 16'h0002; add(B_SEL);
    exp_s.cursor = 4'd2; add(B_RIGHT);
    exp_s.face_up = 16'h0006; exp_s.attempts = 8'd2; add(B_SEL);
    for (int i = 1; i <= 59; i++) add(B_TICK);
    exp_s.face_up = 16'hFFFF; exp_s.lost = 1'b1; add(B_TICK);
    add(B_RIGHT);
    exp_s = '0; add(B_SEL);
    while (stim_q.size() > 0) begin
      b = stim_q.pop_front();
      step(b);
      got = snap();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("FAIL lost[%0d] got %h expected %h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    reset_dut();
    exp_s.face_up = 16'h0001; add(B_SEL);
    exp_s.cursor = 4'd1; add(B_RIGHT);
    exp_s.face_up = 16'h0003; exp_s.attempts = 8'd1; add(B_SEL);
    for (int i = 0; i < 5; i++) add(B_TICK);
    while (stim_q.size() > 0) begin
      b = stim_q.pop_front();
      step(b);
      got = snap();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("FAIL reset_mid_pre[%0d] got %h expected %h", n, got, e); end
      n++;
    end
    #2;
    rst_n = 1'b0;
    exp_s = '0;
    sb.push_back(exp_s);
    #1;
    got = snap();
    e = sb.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL reset_mid_async got %h expected %h", got, e); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_s.face_up = 16'h0001;
    sb.push_back(exp_s);
    step(B_SEL);
    got = snap();
    e = sb.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL reset_mid_after got %h expected %h", got, e); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cursor();
    test_match();
    test_mismatch();
`ifdef ATTEMPT_LIMIT_EN
    test_lost();
`else
    test_ignore();
    test_full_game();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
